// File: rtl/timer16_pkg.sv
// Shared types and default widths for the 16-bit interval timer.
// Imported by timer16_presc and timer16_ctrl.
package timer16_pkg;

    localparam int TIMER_WIDTH   = 16;
    localparam int TIMER_PRESC_W = 8;

    typedef enum logic [1:0] {
        OP_RESUME = 2'b00,
        OP_START  = 2'b01,
        OP_STOP   = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT,
        S_DONE
    } state_e;

endpackage

// File: rtl/timer16_presc.sv
// Prescaler: counts enabled cycles and raises tick every (presc+1) of them.
// Ports: clk, reset (sync, high), enable, clear, presc (P), tick (comb).
module timer16_presc
    import timer16_pkg::*;
#(
    parameter int PRESC_W = TIMER_PRESC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    // Disabled cycles freeze presc_cnt, so a halted timer keeps its phase.
    assign tick = enable && (presc_cnt == presc);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else if (enable) begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer16_ctrl.sv
// Command-driven interval timer: FSM plus up-counter around timer16_presc.
// Ports: clk, reset, cmd_valid/ready/op/period/presc/periodic in;
//        count, busy, done, expire, cmd_err out (all registered).
module timer16_ctrl
    import timer16_pkg::*;
#(
    parameter int WIDTH   = TIMER_WIDTH,
    parameter int PRESC_W = TIMER_PRESC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_period,
    input  logic [PRESC_W-1:0] cmd_presc,
    input  logic               cmd_periodic,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic               expire,
    output logic               cmd_err
);

    state_e             state;
    state_e             state_n;
    logic [WIDTH-1:0]   period_q;
    logic [PRESC_W-1:0] presc_q;
    logic               periodic_q;

    op_e  op;
    logic acc;
    logic do_start;
    logic do_clear;
    logic do_stop;
    logic do_resume;
    logic bad_cmd;
    logic tick;
    logic terminal;

    assign op  = op_e'(cmd_op);
    assign acc = cmd_valid && cmd_ready;

    always_comb begin
        do_start  = 1'b0;
        do_clear  = 1'b0;
        do_stop   = 1'b0;
        do_resume = 1'b0;
        bad_cmd   = 1'b0;
        if (acc) begin
            unique case (op)
                OP_START:  do_start = 1'b1;
                OP_CLEAR:  do_clear = 1'b1;
                OP_STOP: begin
                    do_stop = (state == S_RUN);
                    bad_cmd = (state != S_RUN);
                end
                OP_RESUME: begin
                    do_resume = (state == S_HALT);
                    bad_cmd   = (state != S_HALT);
                end
            endcase
        end
    end

    // A STOP accepted in RUN swallows that cycle's tick, terminal or not.
    timer16_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .enable ((state == S_RUN) && !do_stop),
        .clear  (do_start || do_clear),
        .presc  (presc_q),
        .tick   (tick)
    );

    assign terminal = tick && (count == period_q);

    always_comb begin
        state_n = state;
        unique case (1'b1)
            do_start:  state_n = S_LOAD;
            do_clear:  state_n = S_IDLE;
            do_stop:   state_n = S_HALT;
            do_resume: state_n = S_RUN;
            default: begin
                if (state == S_LOAD) begin
                    state_n = S_RUN;
                end else if (terminal && !periodic_q) begin
                    state_n = S_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            period_q   <= '0;
            presc_q    <= '0;
            periodic_q <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            expire     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n != S_LOAD);
            busy      <= (state_n == S_LOAD) || (state_n == S_RUN);
            done      <= (state_n == S_DONE);
            expire    <= 1'b0;
            cmd_err   <= bad_cmd;
            if (do_start) begin
                period_q   <= cmd_period;
                presc_q    <= cmd_presc;
                periodic_q <= cmd_periodic;
                count      <= '0;
            end else if (do_clear) begin
                count <= '0;
            end else if (terminal) begin
                expire <= 1'b1;
                // One-shot parks at N; periodic wraps to 0.
                if (periodic_q) begin
                    count <= '0;
                end
            end else if (tick) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: doc/timer16_ctrl.md
Name: timer16_ctrl

Overview:
- Command-driven controller that sequences a 16-bit up-counter as a programmable interval timer.
- Supports one-shot and periodic modes, a clock prescaler, and stop/resume.
- Sits between a host command source (valid/ready) and the counter datapath, and signals expiry to downstream logic.

Parameters:
- WIDTH, 16, counter and period width.
- PRESC_W, 8, prescaler width; a tick occurs every (presc+1) RUN cycles.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  command: 00 RESUME, 01 START, 10 STOP, 11 CLEAR.
- cmd_period  in  WIDTH  terminal count N; used by START only.
- cmd_presc  in  PRESC_W  prescale value P; used by START only.
- cmd_periodic  in  1  1 = periodic, 0 = one-shot; used by START only.
- count  out  WIDTH  current counter value.
- busy  out  1  state is LOAD or RUN.
- done  out  1  state is DONE (one-shot finished).
- expire  out  1  one-cycle pulse at terminal count.
- cmd_err  out  1  one-cycle pulse when an accepted command is illegal in the current state.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values (also applied on reset asserted mid-operation): state IDLE, count 0, prescaler counter 0, N/P/mode registers 0, cmd_ready 1, busy 0, done 0, expire 0, cmd_err 0.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_ready is 0 only in LOAD and 1 in every other state.
- States: IDLE, LOAD, RUN, HALT, DONE.
- START is legal in any state except LOAD:
  - latches N, P, mode; count <= 0; presc_cnt <= 0; next state LOAD.
- LOAD lasts exactly one cycle, then moves to RUN unconditionally.
- RUN, each cycle:
  - tick = (presc_cnt == P).
  - On tick: presc_cnt <= 0; otherwise presc_cnt <= presc_cnt + 1.
  - On tick with count != N: count <= count + 1.
  - On tick with count == N:
    - Periodic: count <= 0, expire <= 1.
    - One-shot: count holds N, state <= DONE, expire <= 1.
- Period length: N+1 ticks, i.e. (N+1)*(P+1) RUN cycles.
- N = 0:
  - Periodic: expire fires on every tick.
  - One-shot: DONE on the first tick.
- Counter arithmetic is modulo 2^WIDTH. count never exceeds N.
- STOP:
  - Legal only in RUN; moves to HALT.
  - count and presc_cnt are frozen. The tick on the accepting edge is suppressed: no increment and no expire, and STOP wins over a coincident terminal tick.
- RESUME:
  - Legal only in HALT; returns to RUN with no LOAD cycle.
  - The prescaler continues from its frozen value.
- CLEAR:
  - Legal in any state except LOAD; moves to IDLE with count 0 and presc_cnt 0.
  - N, P and mode are retained.
- Illegal commands (STOP outside RUN, RESUME outside HALT) are accepted, have no state effect, and pulse cmd_err for one cycle.
- DONE holds count = N until a START or CLEAR is accepted.
- expire and cmd_err are high for exactly one cycle per event and never stretch.

Decomposition:
- timer16_pkg:
  - op_e enum (OP_RESUME, OP_START, OP_STOP, OP_CLEAR).
  - state_e enum (S_IDLE, S_LOAD, S_RUN, S_HALT, S_DONE).
  - Default WIDTH and PRESC_W localparams.
- One sub-module, timer16_presc: holds presc_cnt; inputs enable (RUN and no STOP accepted), clear, P; output tick.
- The FSM and the counter register live in timer16_ctrl.

Test Plan:
- START N=3, P=0, one-shot, accepted at edge 0:
  - cmd_ready=0 after edge 0.
  - count 1, 2, 3 after edges 2, 3, 4.
  - expire=1 only after edge 5; done=1 and count=3 thereafter.
- START N=3, P=0, periodic:
  - count sequence 1, 2, 3, 0, 1, ...
  - expire after edges 5, 9, 13 (every 4 cycles); busy stays 1.
- START N=1, P=2, periodic:
  - count increments every 3 RUN cycles.
  - expire every 6 cycles; no expire before the first 6 RUN cycles.
- STOP while count=2 in RUN, hold 5 cycles, then RESUME:
  - count stays 2 and expire stays 0 during HALT.
  - Counting resumes with the prescaler phase preserved.
- STOP in IDLE and RESUME in RUN:
  - cmd_err pulses one cycle each; state and count unchanged.
- Mid-RUN reset with count=7:
  - Next cycle count=0, state IDLE, cmd_ready=1.
  - CLEAR from DONE gives IDLE and count=0.
  - cmd_valid held during LOAD is not accepted until cmd_ready returns.
